// File: rtl/dma_copy_pkg.sv
// Shared types and constants for the data-memory copy engine and port arbiter.
package dma_copy_pkg;

    localparam int DEFAULT_AW = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/dma_copy_ctrl.sv
// Copy engine sharing the single data-memory port with the CPU; CPU always wins and freezes the engine.
// Optional DMA_COPY_FILL_EN adds Fill/FillVal: fill operations skip the read and write FillVal to Dst.
module dma_copy_ctrl
    import dma_copy_pkg::*;
#(
    parameter int AW = DEFAULT_AW
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          CpuReq,
    input  logic [AW-1:0] CpuAddr,
    input  logic          CpuWrite,
    input  logic [7:0]    CpuDataIn,
    output logic [7:0]    CpuDataOut,
    input  logic          Start,
    input  logic [AW-1:0] Src,
    input  logic [AW-1:0] Dst,
    input  logic [AW-1:0] Len,
`ifdef DMA_COPY_FILL_EN
    input  logic          Fill,
    input  logic [7:0]    FillVal,
`endif
    output logic          Busy,
    output logic          Done,
    output logic [AW-1:0] MemAddr,
    output logic          MemWrite,
    output logic [7:0]    MemDataIn,
    input  logic [7:0]    MemDataOut
);

    state_e        state_q, state_d;
    logic [AW-1:0] src_q, src_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [AW-1:0] rem_q, rem_d;
    logic [7:0]    hold_q, hold_d;
    logic          fill_q, fill_d;
    logic          start_fill;

`ifdef DMA_COPY_FILL_EN
    assign start_fill = Fill;
`else
    assign start_fill = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        hold_d  = hold_q;
        fill_d  = fill_q;
        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    if (Len == '0) begin
                        state_d = DONE;
                    end else begin
                        src_d   = Src;
                        dst_d   = Dst;
                        rem_d   = Len;
                        fill_d  = start_fill;
                        state_d = start_fill ? WR : RD;
`ifdef DMA_COPY_FILL_EN
                        // Fill byte lives in the hold register so WR needs no extra mux leg.
                        if (Fill) hold_d = FillVal;
`endif
                    end
                end
            end
            RD: begin
                if (!CpuReq) begin
                    hold_d  = MemDataOut;
                    state_d = WR;
                end
            end
            WR: begin
                if (!CpuReq) begin
                    src_d   = src_q + AW'(1);
                    dst_d   = dst_q + AW'(1);
                    rem_d   = rem_q - AW'(1);
                    state_d = (rem_q == AW'(1)) ? DONE : (fill_q ? WR : RD);
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            hold_q  <= '0;
            fill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            hold_q  <= hold_d;
            fill_q  <= fill_d;
        end
    end

    // Port mux: CPU first, then engine, otherwise a harmless CPU-addressed read.
    always_comb begin
        MemAddr   = CpuAddr;
        MemWrite  = 1'b0;
        MemDataIn = CpuDataIn;
        if (CpuReq) begin
            MemWrite = CpuWrite;
        end else if (state_q == RD) begin
            MemAddr = src_q;
        end else if (state_q == WR) begin
            MemAddr   = dst_q;
            MemWrite  = 1'b1;
            MemDataIn = hold_q;
        end
    end

    assign Busy       = (state_q == RD) || (state_q == WR);
    assign Done       = (state_q == DONE);
    assign CpuDataOut = MemDataOut;

endmodule

// File: tb/tb_dma_copy_ctrl.sv
// Directed bench for dma_copy_ctrl with a behavioural single-port memory; counts cycles from the Start cycle.
module tb_dma_copy_ctrl;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       CpuReq = 1'b0;
    logic [7:0] CpuAddr = 8'h00;
    logic       CpuWrite = 1'b0;
    logic [7:0] CpuDataIn = 8'h00;
    logic [7:0] CpuDataOut;
    logic       Start = 1'b0;
    logic [7:0] Src = 8'h00;
    logic [7:0] Dst = 8'h00;
    logic [7:0] Len = 8'h00;
`ifdef DMA_COPY_FILL_EN
    logic       Fill = 1'b0;
    logic [7:0] FillVal = 8'h00;
`endif
    logic       Busy;
    logic       Done;
    logic [7:0] MemAddr;
    logic       MemWrite;
    logic [7:0] MemDataIn;
    logic [7:0] MemDataOut;

    logic [7:0] mem [256];
    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    always @(posedge CLK) if (MemWrite) mem[MemAddr] <= MemDataIn;
    assign MemDataOut = mem[MemAddr];

    dma_copy_ctrl #(.AW(8)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .CpuReq(CpuReq), .CpuAddr(CpuAddr), .CpuWrite(CpuWrite),
        .CpuDataIn(CpuDataIn), .CpuDataOut(CpuDataOut),
        .Start(Start), .Src(Src), .Dst(Dst), .Len(Len),
`ifdef DMA_COPY_FILL_EN
        .Fill(Fill), .FillVal(FillVal),
`endif
        .Busy(Busy), .Done(Done),
        .MemAddr(MemAddr), .MemWrite(MemWrite),
        .MemDataIn(MemDataIn), .MemDataOut(MemDataOut)
    );

    // Start in cycle 0, then run until Done or budget; optional CPU stores and a Start retry during the copy.
    task automatic run_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] n,
                            input int steal_at, input int steal_n, input int restart_at,
                            output int done_cyc, output int busy_cnt, output int wr_cnt);
        done_cyc = -1;
        busy_cnt = 0;
        wr_cnt   = 0;
        @(posedge CLK); #1;
        Start = 1'b1; Src = s; Dst = d; Len = n;
        for (int cyc = 1; cyc < 60 && done_cyc < 0; cyc++) begin
            @(posedge CLK); #1;
            Start = (cyc == restart_at);
            if (cyc == restart_at) begin
                Src = 8'h40; Dst = 8'hC0; Len = 8'h01;
            end
            CpuReq    = (cyc >= steal_at) && (cyc < steal_at + steal_n);
            CpuWrite  = CpuReq;
            CpuAddr   = 8'h00;
            CpuDataIn = 8'h5A;
            @(negedge CLK);
            if (Busy) busy_cnt++;
            if (MemWrite && !CpuReq) wr_cnt++;
            if (Done) done_cyc = cyc;
        end
        @(posedge CLK); #1;
        Start = 1'b0; CpuReq = 1'b0; CpuWrite = 1'b0;
    endtask

    task automatic test_reset();
        CpuAddr = 8'h33;
        #1;
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", Busy); end
        checks++; if (Done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", Done); end
        checks++; if (MemWrite !== 1'b0) begin failures++; $display("FAIL reset_memwrite got=%b exp=0", MemWrite); end
        checks++; if (MemAddr !== 8'h33) begin failures++; $display("FAIL reset_memaddr got=%h exp=33", MemAddr); end
        @(negedge CLK); RST_N = 1'b1;
        @(negedge CLK);
        checks++; if (Busy !== 1'b0 || Done !== 1'b0) begin failures++; $display("FAIL idle_after_reset busy=%b done=%b exp=0,0", Busy, Done); end
    endtask

    task automatic test_copy();
        int dc, bc, wc;
        logic [7:0] exp_b [4];
        exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33; exp_b[3] = 8'h44;
        for (int i = 0; i < 4; i++) begin mem[8'h10 + i] = exp_b[i]; mem[8'h80 + i] = 8'h00; end
        run_copy(8'h10, 8'h80, 8'd4, 99, 0, 99, dc, bc, wc);
        for (int i = 0; i < 4; i++) begin
            checks++; if (mem[8'h80 + i] !== exp_b[i]) begin failures++; $display("FAIL copy_byte%0d got=%h exp=%h", i, mem[8'h80 + i], exp_b[i]); end
        end
        checks++; if (dc != 9) begin failures++; $display("FAIL copy_done_cycle got=%0d exp=9", dc); end
        checks++; if (bc != 8) begin failures++; $display("FAIL copy_busy_cycles got=%0d exp=8", bc); end
        checks++; if (wc != 4) begin failures++; $display("FAIL copy_writes got=%0d exp=4", wc); end
    endtask

    task automatic test_readpath();
        @(posedge CLK); #1;
        CpuReq = 1'b1; CpuWrite = 1'b0; CpuAddr = 8'h12;
        #1;
        checks++; if (CpuDataOut !== 8'h33) begin failures++; $display("FAIL read_data got=%h exp=33", CpuDataOut); end
        checks++; if (MemAddr !== 8'h12 || MemWrite !== 1'b0) begin failures++; $display("FAIL read_port addr=%h we=%b exp=12,0", MemAddr, MemWrite); end
        CpuReq = 1'b0;
    endtask

    task automatic test_cpu_steal();
        int dc, bc, wc;
        for (int i = 0; i < 4; i++) mem[8'h80 + i] = 8'h00;
        mem[8'h00] = 8'h00;
        run_copy(8'h10, 8'h80, 8'd4, 3, 3, 99, dc, bc, wc);
        checks++; if (mem[8'h00] !== 8'h5A) begin failures++; $display("FAIL steal_cpu_store got=%h exp=5a", mem[8'h00]); end
        checks++; if (mem[8'h80] !== 8'h11 || mem[8'h81] !== 8'h22 || mem[8'h82] !== 8'h33 || mem[8'h83] !== 8'h44) begin
            failures++; $display("FAIL steal_copy got=%h%h%h%h exp=11223344", mem[8'h80], mem[8'h81], mem[8'h82], mem[8'h83]);
        end
        checks++; if (dc != 12) begin failures++; $display("FAIL steal_done_cycle got=%0d exp=12", dc); end
    endtask

    task automatic test_len0();
        int dc, bc, wc;
        run_copy(8'h10, 8'h80, 8'd0, 99, 0, 99, dc, bc, wc);
        checks++; if (dc != 1) begin failures++; $display("FAIL len0_done_cycle got=%0d exp=1", dc); end
        checks++; if (bc != 0) begin failures++; $display("FAIL len0_busy got=%0d exp=0", bc); end
        checks++; if (wc != 0) begin failures++; $display("FAIL len0_writes got=%0d exp=0", wc); end
    endtask

    task automatic test_wrap();
        int dc, bc, wc;
        mem[8'hFE] = 8'hA1; mem[8'hFF] = 8'hB2; mem[8'h00] = 8'hC3;
        mem[8'h01] = 8'h00; mem[8'h02] = 8'h00; mem[8'h03] = 8'h00;
        run_copy(8'hFE, 8'h01, 8'd3, 99, 0, 99, dc, bc, wc);
        checks++; if (mem[8'h01] !== 8'hA1 || mem[8'h02] !== 8'hB2 || mem[8'h03] !== 8'hC3) begin
            failures++; $display("FAIL wrap_copy got=%h%h%h exp=a1b2c3", mem[8'h01], mem[8'h02], mem[8'h03]);
        end
        checks++; if (dc != 7) begin failures++; $display("FAIL wrap_done_cycle got=%0d exp=7", dc); end
    endtask

    task automatic test_overlap();
        int dc, bc, wc;
        mem[8'h50] = 8'h77; mem[8'h51] = 8'h01; mem[8'h52] = 8'h02; mem[8'h53] = 8'h03;
        run_copy(8'h50, 8'h51, 8'd3, 99, 0, 99, dc, bc, wc);
        checks++; if (mem[8'h51] !== 8'h77 || mem[8'h52] !== 8'h77 || mem[8'h53] !== 8'h77) begin
            failures++; $display("FAIL overlap_copy got=%h%h%h exp=777777", mem[8'h51], mem[8'h52], mem[8'h53]);
        end
    endtask

    task automatic test_back_to_back();
        int dc, bc, wc;
        mem[8'hC0] = 8'h00; mem[8'h40] = 8'hEE;
        mem[8'h60] = 8'h9A; mem[8'h61] = 8'hBC; mem[8'h70] = 8'h00; mem[8'h71] = 8'h00;
        run_copy(8'h60, 8'h70, 8'd2, 99, 0, 2, dc, bc, wc);
        checks++; if (dc != 5) begin failures++; $display("FAIL ignored_start_done got=%0d exp=5", dc); end
        checks++; if (mem[8'hC0] !== 8'h00) begin failures++; $display("FAIL ignored_start_write got=%h exp=00", mem[8'hC0]); end
        checks++; if (mem[8'h70] !== 8'h9A || mem[8'h71] !== 8'hBC) begin failures++; $display("FAIL b2b_copy got=%h%h exp=9abc", mem[8'h70], mem[8'h71]); end
    endtask

    task automatic test_abort();
        int dc, bc, wc;
        for (int i = 0; i < 4; i++) mem[8'h90 + i] = 8'h00;
        mem[8'hA0] = 8'h00;
        @(posedge CLK); #1;
        Start = 1'b1; Src = 8'h10; Dst = 8'h90; Len = 8'd4;
        for (int cyc = 1; cyc <= 4; cyc++) begin
            @(posedge CLK); #1;
            Start = 1'b0;
        end
        RST_N = 1'b0;
        #1;
        checks++; if (Busy !== 1'b0 || MemWrite !== 1'b0) begin failures++; $display("FAIL abort_immediate busy=%b we=%b exp=0,0", Busy, MemWrite); end
        @(negedge CLK); RST_N = 1'b1;
        checks++; if (mem[8'h90] !== 8'h11 || mem[8'h91] !== 8'h00) begin failures++; $display("FAIL abort_bytes got=%h%h exp=1100", mem[8'h90], mem[8'h91]); end
        run_copy(8'h10, 8'hA0, 8'd1, 99, 0, 99, dc, bc, wc);
        checks++; if (dc != 3 || mem[8'hA0] !== 8'h11) begin failures++; $display("FAIL restart_after_abort done=%0d byte=%h exp=3,11", dc, mem[8'hA0]); end
    endtask

`ifdef DMA_COPY_FILL_EN
    task automatic test_fill();
        int dc, bc, wc;
        mem[8'h20] = 8'h00; mem[8'h21] = 8'h00; mem[8'h22] = 8'h00; mem[8'h23] = 8'h00; mem[8'hC0] = 8'h00;
        Fill = 1'b1; FillVal = 8'hA5;
        run_copy(8'h10, 8'h20, 8'd3, 99, 0, 2, dc, bc, wc);
        Fill = 1'b0;
        checks++; if (mem[8'h20] !== 8'hA5 || mem[8'h21] !== 8'hA5 || mem[8'h22] !== 8'hA5 || mem[8'h23] !== 8'h00) begin
            failures++; $display("FAIL fill_bytes got=%h%h%h%h exp=a5a5a500", mem[8'h20], mem[8'h21], mem[8'h22], mem[8'h23]);
        end
        checks++; if (dc != 4) begin failures++; $display("FAIL fill_done_cycle got=%0d exp=4", dc); end
        checks++; if (mem[8'hC0] !== 8'h00) begin failures++; $display("FAIL fill_ignored_start got=%h exp=00", mem[8'hC0]); end
    endtask
`endif

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        test_reset();
        test_copy();
        test_readpath();
        test_cpu_steal();
        test_len0();
        test_wrap();
        test_overlap();
        test_back_to_back();
        test_abort();
`ifdef DMA_COPY_FILL_EN
        test_fill();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dma_copy_ctrl.md
Name: dma_copy_ctrl

Overview:
Sequencer and arbiter for the single-port 8-bit data memory. It shares the port between the CPU load/store path and an internal copy engine. The copy engine moves Len bytes from Src to Dst inside data memory. The CPU has absolute priority; the engine stalls whenever the CPU uses the port. The block sits between the core datapath and the data memory instance.

Parameters:
AW, 8, data memory address width (depth 2**AW)

Ports:
CLK  in  1  clock, all state on rising edge
RST_N  in  1  asynchronous active-low reset
CpuReq  in  1  CPU owns memory port this cycle (load or store)
CpuAddr  in  AW  CPU address
CpuWrite  in  1  CPU store enable (qualified by CpuReq)
CpuDataIn  in  8  CPU store data
CpuDataOut  out  8  load data, combinational copy of MemDataOut
Start  in  1  start copy (sampled only in IDLE)
Src  in  AW  copy source base address
Dst  in  AW  copy destination base address
Len  in  AW  byte count; 0 = no-op
Busy  out  1  copy in progress
Done  out  1  one-cycle completion pulse
MemAddr  out  AW  to data memory address
MemWrite  out  1  to data memory write enable
MemDataIn  out  8  to data memory write data
MemDataOut  in  8  from data memory, combinational read

Behaviour:
- Clock and reset: one clock, CLK. Reset RST_N is asynchronous, active-low. Reset mid-operation aborts the copy immediately; no further writes occur.
- Reset values: state IDLE, Busy=0, Done=0, all internal registers (pointers, remaining count, hold byte) 0.
- FSM states: IDLE, RD, WR, DONE.
- IDLE:
  - Start=1 and Len!=0: latch Src, Dst, Len; go to RD.
  - Start=1 and Len==0: go to DONE.
  - Start is ignored in every other state; no queuing.
- RD (engine not stalled): MemAddr=src_ptr. Capture MemDataOut into hold at the edge. Go to WR.
- WR (engine not stalled): MemAddr=dst_ptr, MemWrite=1, MemDataIn=hold. At the edge, increment src_ptr and dst_ptr and decrement rem.
  - rem==1 before the edge: go to DONE.
  - Otherwise: go to RD.
- DONE: Done=1 for exactly one cycle, then IDLE.
- Busy=1 in RD and WR only.
- Arbitration:
  - CpuReq=1: port mux selects the CPU (MemAddr=CpuAddr, MemWrite=CpuWrite, MemDataIn=CpuDataIn). Engine state, pointers and hold are frozen that cycle.
  - CpuReq=1 coinciding with DONE or IDLE has no effect on the engine.
- Idle port: with CpuReq=0 outside RD/WR, MemWrite=0 and MemAddr=CpuAddr.
- Pointer wrap: pointers wrap modulo 2**AW (0xFF+1 -> 0x00 at AW=8).
- Overlap: copies are strictly ascending, byte by byte. Overlapping ranges with Dst>Src replicate the source pattern; this is defined behaviour, not an error.
- Latency: uncontended copy of N bytes asserts Done in cycle 2N+1 after the Start cycle. Each CPU-stolen cycle during RD/WR adds one cycle. Len=0 asserts Done in cycle 1.
- Read-data path: CpuDataOut = MemDataOut always, no registering.

Optional Feature:
DMA_COPY_FILL_EN
- Defined:
  - Adds input Fill (1) and input FillVal (8).
  - Fill is latched at Start. A fill operation skips RD: IDLE -> WR.
  - WR writes FillVal to dst_ptr; src_ptr is unused.
  - N bytes complete with Done in cycle N+1.
- Undefined: ports are absent and all operations are copies.

Decomposition:
- Package dma_copy_pkg:
  - state enum type (IDLE, RD, WR, DONE) as a 2-bit logic typedef.
  - constant DEFAULT_AW=8.
- No sub-module. The port mux is a single always_comb inside the block; the FSM, pointers and remaining counter are one always_ff with asynchronous reset.

Test Plan:
- Reset, then Start, Src=0x10, Dst=0x80, Len=4, memory[0x10..0x13]=11,22,33,44, CpuReq=0 -> memory[0x80..0x83]=11,22,33,44; Busy high cycles 1-8; Done pulse cycle 9.
- Same copy with CpuReq=1 for 3 cycles starting at cycle 3 (CPU store 0x5A to 0x00) -> memory[0x00]=0x5A; copy intact; Done at cycle 12.
- Len=0 Start -> no MemWrite; Done pulse cycle 1; Busy never high.
- Src=0xFE, Dst=0x01, Len=3 -> reads 0xFE, 0xFF, 0x00 (wrap); writes 0x01..0x03.
- RST_N low at cycle 4 of a Len=4 copy -> Busy=0 immediately; only byte 0 written; Start in the next cycle after release accepted.
- With DMA_COPY_FILL_EN: Fill=1, FillVal=0xA5, Dst=0x20, Len=3 -> memory[0x20..0x22]=A5; Done cycle 4; Start during Busy ignored.
